// File: rtl/mcycle_sequencer.sv
// -----------------------------------------------------------------------------
// mcycle_sequencer
// Sequences the shared multi-cycle multiply/divide unit for the control path.
// A condition-qualified request is accepted in IDLE, its operands and
// destination are latched, the unit is started, and the PC/register-file
// update is stalled until the unit reports done. The result is then written
// back for one cycle. Divide-by-zero bypasses the unit with an all-ones
// result; a watchdog abandons the operation after MAX_CYCLES wait cycles.
//
// Ports
//   CLK, RESET_N        clock (rising edge), asynchronous active-low reset
//   Req, CondEx         decoder request and condition-pass qualifier
//   Op, Rd              operation (0=MUL, 1=DIV) and destination register
//   SrcA, SrcB          operands
//   MC_Start            one-cycle start pulse to the unit
//   MC_Op, MC_Operand*  operation/operands latched at accept
//   MC_Done, MC_Result  unit completion pulse and its result
//   Stall               hold PC, suppress normal RegWrite (combinational)
//   WE, WA, WD          one-cycle write-back port
//   Busy                sequencer is not idle
//   Timeout             sticky watchdog flag, cleared by the next accept
// -----------------------------------------------------------------------------
module mcycle_sequencer #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MAX_CYCLES = 40
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             Req,
    input  logic             CondEx,
    input  logic             Op,
    input  logic [3:0]       Rd,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             MC_Start,
    output logic             MC_Op,
    output logic [WIDTH-1:0] MC_Operand1,
    output logic [WIDTH-1:0] MC_Operand2,
    input  logic             MC_Done,
    input  logic [WIDTH-1:0] MC_Result,
    output logic             Stall,
    output logic             WE,
    output logic [3:0]       WA,
    output logic [WIDTH-1:0] WD,
    output logic             Busy,
    output logic             Timeout
);

    localparam int unsigned CNT_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_WB    = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;

    logic              r_op;
    logic [3:0]        r_rd;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_res;
    logic              r_to;

    logic              w_accept;
    logic              w_div0;
    logic              w_latch;
    logic              w_cap;
    logic              w_set_to;
    logic              w_start;
    logic              w_stall;
    logic              w_we;

    assign w_accept = (r_state == S_IDLE) && Req && CondEx;
    assign w_div0   = Op && (SrcB == '0);

    // State register and wait counter
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state and control decode
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_latch    = 1'b0;
        w_cap      = 1'b0;
        w_set_to   = 1'b0;
        w_start    = 1'b0;
        w_stall    = 1'b0;
        w_we       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_latch = 1'b1;
                    w_stall = 1'b1;
                    // Divide-by-zero never reaches the unit
                    w_next  = w_div0 ? S_WB : S_START;
                end
            end
            S_START: begin
                w_start    = 1'b1;
                w_stall    = 1'b1;
                w_cnt_next = '0;
                w_next     = S_WAIT;
            end
            S_WAIT: begin
                // Done wins over the watchdog on the final wait cycle
                if (MC_Done) begin
                    w_cap   = 1'b1;
                    w_stall = 1'b1;
                    w_next  = S_WB;
                end else if (r_cnt == CNT_LAST) begin
                    // Stall released so the PC moves past the abandoned op
                    w_set_to = 1'b1;
                    w_next   = S_IDLE;
                end else begin
                    w_stall    = 1'b1;
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            S_WB: begin
                // Req here is the same instruction; it is not re-accepted
                w_we   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Operand, destination, result and watchdog-flag registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_op  <= 1'b0;
            r_rd  <= 4'd0;
            r_a   <= '0;
            r_b   <= '0;
            r_res <= '0;
            r_to  <= 1'b0;
        end else begin
            if (w_latch) begin
                r_op <= Op;
                r_rd <= Rd;
                r_a  <= SrcA;
                r_b  <= SrcB;
                r_to <= 1'b0;
                if (w_div0) begin
                    r_res <= '1;
                end
            end
            if (w_cap) begin
                r_res <= MC_Result;
            end
            if (w_set_to) begin
                r_to <= 1'b1;
            end
        end
    end

    assign MC_Start    = w_start;
    assign MC_Op       = r_op;
    assign MC_Operand1 = r_a;
    assign MC_Operand2 = r_b;
    assign Stall       = w_stall;
    assign WE          = w_we;
    assign WA          = w_we ? r_rd : 4'd0;
    assign WD          = w_we ? r_res : '0;
    assign Busy        = (r_state != S_IDLE);
    assign Timeout     = r_to;

endmodule

// File: tb/tb_mcycle_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mcycle_sequencer
// Directed scenarios followed by randomized traffic. The reference model
// tracks each accepted instruction by its age in cycles since accept and
// derives every output from that age.
// -----------------------------------------------------------------------------
module tb_mcycle_sequencer;

    localparam int unsigned W    = 32;
    localparam int          MAXC = 8;

    logic         CLK = 1'b0;
    logic         RESET_N;
    logic         Req, CondEx, Op;
    logic [3:0]   Rd;
    logic [W-1:0] SrcA, SrcB;
    logic         MC_Start, MC_Op;
    logic [W-1:0] MC_Operand1, MC_Operand2;
    logic         MC_Done;
    logic [W-1:0] MC_Result;
    logic         Stall, WE, Busy, Timeout;
    logic [3:0]   WA;
    logic [W-1:0] WD;

    mcycle_sequencer #(.WIDTH(W), .MAX_CYCLES(MAXC)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .Req(Req), .CondEx(CondEx), .Op(Op),
        .Rd(Rd), .SrcA(SrcA), .SrcB(SrcB), .MC_Start(MC_Start), .MC_Op(MC_Op),
        .MC_Operand1(MC_Operand1), .MC_Operand2(MC_Operand2),
        .MC_Done(MC_Done), .MC_Result(MC_Result), .Stall(Stall), .WE(WE),
        .WA(WA), .WD(WD), .Busy(Busy), .Timeout(Timeout)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: an accepted instruction and its age since accept
    bit           m_busy, m_div0, m_op, m_to;
    int           m_age, m_wb_age;
    logic [3:0]   m_rd;
    logic [W-1:0] m_a, m_b, m_res;

    // Observations collected per directed scenario
    int           o_stall, o_start, o_we;
    logic [3:0]   o_wa;
    logic [W-1:0] o_wd;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_busy = 0; m_div0 = 0; m_op = 0; m_to = 0;
        m_age = 0; m_wb_age = 0; m_rd = '0; m_a = '0; m_b = '0; m_res = '0;
    endtask

    task automatic clr_obs();
        o_stall = 0; o_start = 0; o_we = 0; o_wa = '0; o_wd = '0;
    endtask

    // Compare all DUT outputs against the model for the current cycle
    task automatic compare();
        bit e_start, e_wait, e_exit, e_stall, e_we;
        e_start = m_busy && !m_div0 && (m_age == 1);
        e_wait  = m_busy && !m_div0 && (m_age >= 2) && (m_wb_age == 0);
        e_exit  = e_wait && (m_age - 1 == MAXC) && !MC_Done;
        e_stall = (!m_busy && Req && CondEx) || e_start || (e_wait && !e_exit);
        e_we    = m_busy && (m_age == m_wb_age);
        chk("MC_Start", W'(MC_Start), W'(e_start));
        chk("Stall",    W'(Stall),    W'(e_stall));
        chk("WE",       W'(WE),       W'(e_we));
        chk("Busy",     W'(Busy),     W'(m_busy));
        chk("Timeout",  W'(Timeout),  W'(m_to));
        chk("MC_Op",    W'(MC_Op),    W'(m_op));
        chk("MC_Operand1", MC_Operand1, m_a);
        chk("MC_Operand2", MC_Operand2, m_b);
        if (e_we) begin
            chk("WA", W'(WA), W'(m_rd));
            chk("WD", WD, m_res);
        end
        o_stall += int'(Stall);
        o_start += int'(MC_Start);
        if (WE) begin
            o_we++; o_wa = WA; o_wd = WD;
        end
    endtask

    // Advance the model by one rising edge using the inputs the DUT sees
    task automatic model_update();
        if (m_busy) begin
            if (m_age == m_wb_age) begin
                m_busy = 0;
            end else if (!m_div0 && m_age >= 2) begin
                if (MC_Done) begin
                    m_res = MC_Result;
                    m_wb_age = m_age + 1;
                end else if (m_age - 1 == MAXC) begin
                    m_to = 1; m_busy = 0;
                end
            end
            m_age++;
        end else if (Req && CondEx) begin
            m_busy = 1; m_age = 1; m_to = 0;
            m_op = Op; m_rd = Rd; m_a = SrcA; m_b = SrcB;
            m_div0 = Op && (SrcB == '0);
            m_wb_age = m_div0 ? 1 : 0;
            if (m_div0) m_res = '1;
        end
    endtask

    task automatic step();
        @(negedge CLK);
        compare();
        @(posedge CLK);
        model_update();
        #1;
    endtask

    task automatic drive(input bit req, input bit cex, input bit op, input logic [3:0] rd,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit done, input logic [W-1:0] res);
        Req = req; CondEx = cex; Op = op; Rd = rd; SrcA = a; SrcB = b;
        MC_Done = done; MC_Result = res;
        step();
    endtask

    // Asynchronous reset pulse in mid-cycle; outputs must clear immediately
    task automatic pulse_reset();
        Req = 0; CondEx = 0; MC_Done = 0;
        RESET_N = 0;
        model_reset();
        #1;
        chk("rst Busy",     W'(Busy),     '0);
        chk("rst MC_Start", W'(MC_Start), '0);
        chk("rst Stall",    W'(Stall),    '0);
        chk("rst WE",       W'(WE),       '0);
        chk("rst Timeout",  W'(Timeout),  '0);
        chk("rst MC_Op",    W'(MC_Op),    '0);
        chk("rst Operand1", MC_Operand1,  '0);
        chk("rst Operand2", MC_Operand2,  '0);
        @(negedge CLK);
        compare();
        #2 RESET_N = 1;
        @(posedge CLK);
        model_update();
        #1;
    endtask

    initial begin
        RESET_N = 0; Req = 0; CondEx = 0; Op = 0; Rd = '0; SrcA = '0; SrcB = '0;
        MC_Done = 0; MC_Result = '0;
        model_reset();
        clr_obs();
        #2;
        chk("init Busy",    W'(Busy),    '0);
        chk("init Stall",   W'(Stall),   '0);
        chk("init WE",      W'(WE),      '0);
        chk("init Timeout", W'(Timeout), '0);
        @(negedge CLK);
        RESET_N = 1;
        @(posedge CLK);
        #1;

        // MUL 7*6 -> r3, done on third wait cycle
        clr_obs();
        drive(1, 1, 0, 4'd3, 32'd7, 32'd6, 0, '0);
        drive(1, 1, 0, 4'd3, 32'd7, 32'd6, 0, '0);
        drive(1, 1, 0, 4'd3, 32'd7, 32'd6, 0, '0);
        drive(1, 1, 0, 4'd3, 32'd7, 32'd6, 0, '0);
        drive(1, 1, 0, 4'd3, 32'd7, 32'd6, 1, 32'd42);
        drive(1, 1, 0, 4'd3, 32'd7, 32'd6, 0, '0);
        drive(0, 0, 0, 4'd0, '0, '0, 0, '0);
        chk("mul starts", W'(o_start), W'(1));
        chk("mul stalls", W'(o_stall), W'(5));
        chk("mul wes",    W'(o_we),    W'(1));
        chk("mul wa",     W'(o_wa),    W'(3));
        chk("mul wd",     o_wd,        32'd42);
        chk("mul busy",   W'(Busy),    '0);
        chk("mul op",     W'(MC_Op),   '0);

        // DIV 100/0 -> r5, bypasses the unit
        clr_obs();
        drive(1, 1, 1, 4'd5, 32'd100, '0, 0, '0);
        drive(1, 1, 1, 4'd5, 32'd100, '0, 0, '0);
        drive(0, 0, 0, 4'd0, '0, '0, 0, '0);
        chk("div0 starts", W'(o_start), '0);
        chk("div0 stalls", W'(o_stall), W'(1));
        chk("div0 wes",    W'(o_we),    W'(1));
        chk("div0 wa",     W'(o_wa),    W'(5));
        chk("div0 wd",     o_wd,        32'hFFFF_FFFF);

        // Condition failed: ignored
        clr_obs();
        drive(1, 0, 0, 4'd2, 32'd1, 32'd2, 0, '0);
        drive(1, 0, 0, 4'd2, 32'd1, 32'd2, 0, '0);
        chk("cex0 stalls", W'(o_stall), '0);
        chk("cex0 starts", W'(o_start), '0);
        chk("cex0 busy",   W'(Busy),    '0);

        // Watchdog: unit never answers
        clr_obs();
        for (int i = 0; i < 2 + MAXC; i++) drive(1, 1, 0, 4'd9, 32'd3, 32'd4, 0, '0);
        drive(0, 0, 0, 4'd0, '0, '0, 0, '0);
        chk("to flag",   W'(Timeout), W'(1));
        chk("to wes",    W'(o_we),    '0);
        chk("to busy",   W'(Busy),    '0);
        chk("to stalls", W'(o_stall), W'(MAXC + 1));

        // Done on the last permitted wait cycle beats the watchdog
        clr_obs();
        drive(1, 1, 0, 4'd7, 32'd5, 32'd8, 0, '0);
        chk("to cleared", W'(Timeout), '0);
        for (int i = 0; i < MAXC; i++) drive(1, 1, 0, 4'd7, 32'd5, 32'd8, 0, '0);
        drive(1, 1, 0, 4'd7, 32'd5, 32'd8, 1, 32'hDEAD);
        drive(1, 1, 0, 4'd7, 32'd5, 32'd8, 0, '0);
        drive(0, 0, 0, 4'd0, '0, '0, 0, '0);
        chk("last wes",    W'(o_we),    W'(1));
        chk("last wd",     o_wd,        32'hDEAD);
        chk("last to",     W'(Timeout), '0);
        chk("last stalls", W'(o_stall), W'(MAXC + 2));

        // Reset during WAIT, late done ignored, then back-to-back ops
        clr_obs();
        drive(1, 1, 0, 4'd4, 32'd2, 32'd2, 0, '0);
        drive(1, 1, 0, 4'd4, 32'd2, 32'd2, 0, '0);
        drive(1, 1, 0, 4'd4, 32'd2, 32'd2, 0, '0);
        pulse_reset();
        drive(0, 0, 0, 4'd0, '0, '0, 1, 32'd99);
        drive(0, 0, 0, 4'd0, '0, '0, 1, 32'd99);
        chk("rst wes", W'(o_we), '0);
        clr_obs();
        drive(1, 1, 0, 4'd1, 32'd3, 32'd3, 0, '0);
        drive(1, 1, 0, 4'd1, 32'd3, 32'd3, 0, '0);
        drive(1, 1, 0, 4'd1, 32'd3, 32'd3, 1, 32'd9);
        drive(1, 1, 0, 4'd1, 32'd3, 32'd3, 0, '0);
        drive(1, 1, 1, 4'd6, 32'd8, '0, 0, '0);
        drive(1, 1, 1, 4'd6, 32'd8, '0, 0, '0);
        drive(0, 0, 0, 4'd0, '0, '0, 0, '0);
        chk("b2b wes", W'(o_we), W'(2));
        chk("b2b wd",  o_wd,     32'hFFFF_FFFF);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                pulse_reset();
            end else begin
                drive($urandom_range(0, 9) < 4, $urandom_range(0, 3) != 0,
                      1'($urandom_range(0, 1)), 4'($urandom),
                      W'($urandom), ($urandom_range(0, 3) == 0) ? '0 : W'($urandom),
                      $urandom_range(0, 11) == 0, W'($urandom));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mcycle_sequencer.md
Name: mcycle_sequencer

Overview:
- Sequences the shared multi-cycle multiply/divide unit on behalf of the processor's control path.
- Accepts a condition-qualified request from the decoder, latches the operands and destination register, and pulses start to the unit.
- Stalls PC/register-file update until the unit reports done, then issues a one-cycle register write-back.
- Short-circuits divide-by-zero and enforces a watchdog timeout.

Parameters:
WIDTH, 32, operand/result width
MAX_CYCLES, 40, max WAIT cycles before timeout (>=2)

Ports:
CLK  in  1  clock, rising edge
RESET_N  in  1  asynchronous active-low reset
Req  in  1  multi-cycle request from decoder (M_Start)
CondEx  in  1  condition-pass for current instruction
Op  in  1  0=MUL, 1=DIV
Rd  in  4  destination register of current instruction
SrcA  in  WIDTH  operand 1
SrcB  in  WIDTH  operand 2
MC_Start  out  1  start pulse to multi-cycle unit
MC_Op  out  1  latched operation to unit
MC_Operand1  out  WIDTH  latched SrcA
MC_Operand2  out  WIDTH  latched SrcB
MC_Done  in  1  unit completion (single-cycle pulse)
MC_Result  in  WIDTH  unit result, valid when MC_Done=1
Stall  out  1  hold PC and suppress normal RegWrite
WE  out  1  write-back enable
WA  out  4  write-back address
WD  out  WIDTH  write-back data
Busy  out  1  state != IDLE
Timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (async, RESET_N=0):
  - state=IDLE; counter=0.
  - Latched Op/Rd/operands/result=0.
  - Timeout=0; all outputs 0.
- States: IDLE, START, WAIT, WB.
- IDLE:
  - Accept when Req&CondEx=1: latch Op, Rd, SrcA, SrcB; clear Timeout.
  - If Op=1 and SrcB==0: result={WIDTH{1'b1}}, go WB, skip unit.
  - Otherwise go START.
  - Req&~CondEx: ignored, no state change.
- START:
  - MC_Start=1 for exactly this cycle.
  - counter<=0; go WAIT.
- WAIT:
  - MC_Done=1: capture MC_Result, go WB.
  - Else if counter==MAX_CYCLES-1: Timeout<=1, go IDLE, no write-back.
  - Else counter++.
  - MC_Done has priority over timeout in the same cycle.
- WB:
  - WE=1, WA=latched Rd, WD=latched result for one cycle.
  - Go IDLE. Req is ignored in WB (same instruction still presented).
- Stall (combinational) = (IDLE & Req & CondEx) | START | WAIT.
  - Stall=0 in WB so the PC advances at the end of the WB cycle.
  - Stall=0 on the timeout exit cycle; the PC then advances at the end of that cycle.
- MC_Op and MC_Operand1/2 hold latched values from accept until the next accept.
- Busy=1 in START, WAIT, WB.
- Latency, normal: accept cycle + START + N wait cycles (N = cycles until MC_Done) + WB. Stall is high for N+2 cycles.
- Latency, div-by-zero: accept + WB; Stall high 1 cycle; MC_Start never asserted.
- MC_Done outside WAIT is ignored.
- Reset mid-operation returns to IDLE with no WE; a later MC_Done is ignored.
- Timeout stays 1 until the next accepted request or reset.

Test Plan:
- MUL 7×6, Rd=3, MC_Done with MC_Result=42 on the 3rd WAIT cycle -> one MC_Start pulse, MC_Op=0, Stall high 5 cycles, then WE=1/WA=3/WD=42 for one cycle, Busy low after.
- DIV 100/0, Rd=5 -> MC_Start never high, Stall high 1 cycle, next cycle WE=1/WA=5/WD=0xFFFFFFFF.
- Req=1, CondEx=0 -> Stall=0, MC_Start=0, WE=0, state stays IDLE.
- MAX_CYCLES=8, MC_Done never asserted -> after 8 WAIT cycles Timeout=1, WE never asserted, Busy=0. Timeout clears on next accepted request.
- MAX_CYCLES=8, MC_Done=1 on the 8th WAIT cycle -> WB taken with the result, Timeout stays 0.
- RESET_N pulsed low during WAIT, then MC_Done -> outputs 0 immediately (async), no WE afterwards. Back-to-back requests after reset operate normally.
